ps2_frame_rx: RTL and testbench
===============================

// Module: ps2_frame_rx
// PURPOSE
// - Receives PS/2 keyboard serial frames from the raw kbd_clk/kbd_dat lines.
// - Frame format: start(0), 8 data bits LSB-first, odd parity, stop(1).
// - Delivers each good byte as dout[7:0] with a 1-cycle dout_new strobe.
// - Sits directly upstream of the scan-code byte recogniser, which consumes dout/dout_new.
// PARAMETERS
// FILTER_LEN   4      consecutive equal sync samples required to change filtered kbd_clk
// TIMEOUT_CYC  25000  idle clk cycles between falling edges before a partial frame is aborted (500us @50MHz)
// PORTS
// clk         in   1  system clock
// resetN      in   1  async active-low reset
// kbd_clk     in   1  raw PS/2 clock pin (asynchronous)
// kbd_dat     in   1  raw PS/2 data pin (asynchronous)
// dout        out  8  last good received byte; held until the next good frame
// dout_new    out  1  1-cycle pulse: dout just updated
// parity_err  out  1  1-cycle pulse: frame dropped, parity not odd
// frame_err   out  1  1-cycle pulse: frame dropped, stop bit = 0
// BEHAVIOUR
// - Reset (async, resetN=0): dout=8'h00, dout_new=0, parity_err=0, frame_err=0.
//   Also: FSM=IDLE, bit counter=0, timeout counter=0, filtered clk=1, sync FFs=1.
//   Reset mid-frame discards the partial frame.
// - Input sync: 2-FF synchroniser on kbd_clk and on kbd_dat.
// - Clock filter: filtered clk toggles only after FILTER_LEN consecutive synced samples differ from it.
// - Falling-edge detect (fe): 1-cycle pulse when the filtered clk goes 1->0.
//   Synced kbd_dat is sampled in the fe cycle.
// - FSM states and transitions:
//   IDLE:   fe & dat=0 -> DATA (bitcnt=0). fe & dat=1 -> stay IDLE (spurious start ignored).
//   DATA:   each fe shifts shreg <= {dat, shreg[7:1]}, bitcnt++. On the 8th fe -> PARITY.
//   PARITY: fe stores the parity bit -> STOP.
//   STOP:   fe checks the frame, then -> IDLE.
//     ok = stop bit is 1 AND ^{shreg, parity} = 1.
//     If ok: dout <= shreg and dout_new=1 in the next cycle.
//     If stop = 0: frame_err=1 next cycle, dout unchanged.
//     Else (stop = 1, parity bad): parity_err=1 next cycle, dout unchanged.
//     If stop = 0 and parity is also bad, only frame_err is raised.
// - Latency: dout_new is asserted exactly 1 clk after the stop-bit fe cycle.
// - dout is stable for at least 1 cycle after dout_new.
//   Downstream samples dout one cycle after the strobe, so dout must never change except on a good frame.
// - Timeout: counter clears on every fe and while in IDLE.
//   In any non-IDLE state, reaching TIMEOUT_CYC-1 -> IDLE with no output pulse.
// - Strobes are mutually exclusive and never back-to-back within one frame.
// - Minimum spacing between strobes is one full PS/2 frame.
// - No transmit to the keyboard: kbd_clk/kbd_dat are inputs only.
// TESTING
// (PS/2 bit period 40us, FILTER_LEN=4 unless stated)
// 1. Frame 0x1C (bits 0,0,1,1,1,0,0,0; parity 0; stop 1)
//    -> dout=8'h1C, one dout_new pulse 1 clk after the stop fe, no error pulses.
// 2. Frames 0xF0 (parity 1) then 0x1C -> two dout_new pulses, dout=8'hF0 then 8'h1C.
//    dout holds 8'hF0 for the whole gap between frames.
// 3. Frame 0x5A sent with parity 0 (bad) -> parity_err pulse, no dout_new, dout keeps its previous value.
//    Same frame with stop=0 -> frame_err pulse only.
// 4. Start bit + 3 data bits, then the lines are held high for TIMEOUT_CYC+10 cycles
//    -> FSM returns to IDLE with no pulses. A following 0x5A frame gives dout=8'h5A.
// 5. A 2-clk low glitch on kbd_clk during DATA -> no fe, no bit shifted; the frame completes correctly.
//    A 4-clk low glitch produces an fe.
// 6. resetN pulsed low after 5 data bits -> all outputs 0 immediately.
//    The next full 0x1C frame is received correctly.

Source files
------------

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
// ps2_frame_rx : PS/2 device-to-host frame receiver with clock deglitch and
//                partial-frame timeout.  Rev 1.0
// ============================================================================
module ps2_frame_rx #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 25000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       kbd_clk,
  input  logic       kbd_dat,
  output logic [7:0] dout,
  output logic       dout_new,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FW-1:0] filt_cnt;
  logic          filt_clk, filt_clk_d;
  logic          fe;
  state_t        state, state_nx;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          do_start, do_shift, do_par, do_check;
  logic          parity_bad;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      filt_cnt   <= '0;
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
    end else begin
      clk_s1     <= kbd_clk;
      clk_s2     <= clk_s1;
      dat_s1     <= kbd_dat;
      dat_s2     <= dat_s1;
      filt_clk_d <= filt_clk;
      // Any sample agreeing with the filtered level restarts the run count
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_clk <= ~filt_clk;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fe = filt_clk_d & ~filt_clk;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    do_start = 1'b0;
    do_shift = 1'b0;
    do_par   = 1'b0;
    do_check = 1'b0;
    case (state)
      IDLE: begin
        if (fe && !dat_s2) begin
          do_start = 1'b1;
          state_nx = DATA;
        end
      end
      DATA: begin
        if (fe) begin
          do_shift = 1'b1;
          if (bitcnt == 3'd7) state_nx = PARITY;
        end
      end
      PARITY: begin
        if (fe) begin
          do_par   = 1'b1;
          state_nx = STOP;
        end
      end
      STOP: begin
        if (fe) begin
          do_check = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // A stalled keyboard must not leave a half frame pending forever
    if (state != IDLE && !fe && tcnt == TO_LAST) state_nx = IDLE;
  end

  assign parity_bad = ~(^{shreg, par_bit});

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bitcnt     <= 3'd0;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      dout       <= 8'h00;
      dout_new   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (state == IDLE || fe) tcnt <= '0;
      else                     tcnt <= tcnt + 1'b1;

      if (do_start) bitcnt <= 3'd0;
      if (do_shift) begin
        shreg  <= {dat_s2, shreg[7:1]};
        bitcnt <= bitcnt + 1'b1;
      end
      if (do_par) par_bit <= dat_s2;

      // A bad stop bit dominates: only frame_err in that case
      dout_new   <= do_check &  dat_s2 & ~parity_bad;
      parity_err <= do_check &  dat_s2 &  parity_bad;
      frame_err  <= do_check & ~dat_s2;
      if (do_check && dat_s2 && !parity_bad) dout <= shreg;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_frame_rx.sv
`default_nettype none
// tb_ps2_frame_rx : randomized PS/2 frames scored against a bit-list reference
// model; a monitor pops expected strobes from a queue and compares.
`timescale 1ns/1ps
module tb_ps2_frame_rx;

  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 300;
  localparam int HALF        = 20;  // scaled-down half bit period in clk cycles

  logic       clk    = 1'b0;
  logic       resetN = 1'b1;
  logic       kbd_clk = 1'b1;
  logic       kbd_dat = 1'b1;
  logic [7:0] dout;
  logic       dout_new, parity_err, frame_err;

  ps2_frame_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .kbd_clk    (kbd_clk),
    .kbd_dat    (kbd_dat),
    .dout       (dout),
    .dout_new   (dout_new),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = good byte, 1 = parity error, 2 = framing error
  typedef struct {
    int          kind;
    logic [7:0]  data;
    int unsigned edge_cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  model_dout = 8'h00;
  bit          rx_bits[$];
  int unsigned last_sample_cyc = 0;

  // Reference model: every filtered falling edge yields one data sample;
  // frames are 11 samples starting at a 0, aborted by a long quiet gap.
  task automatic model_sample(input bit b);
    exp_t e;
    int   ones;
    if (rx_bits.size() != 0 && (cyc - last_sample_cyc) > TIMEOUT_CYC) rx_bits.delete();
    last_sample_cyc = cyc;
    if (rx_bits.size() == 0 && b) return;
    rx_bits.push_back(b);
    if (rx_bits.size() == 11) begin
      e.data = 8'h00;
      ones   = 0;
      for (int i = 0; i < 8; i++) begin
        e.data[i] = rx_bits[i+1];
        ones += int'(rx_bits[i+1]);
      end
      ones += int'(rx_bits[9]);
      if (!rx_bits[10])     e.kind = 2;
      else if (ones % 2 == 1) e.kind = 0;
      else                  e.kind = 1;
      e.edge_cyc = cyc;
      sb.push_back(e);
      rx_bits.delete();
    end
  endtask

  task automatic drive_bit(input bit b, input int glen);
    kbd_dat = b;
    kbd_clk = 1'b1;
    if (glen > 0) begin
      repeat (6) @(negedge clk);
      kbd_clk = 1'b0;
      if (glen >= FILTER_LEN) model_sample(b);
      repeat (glen) @(negedge clk);
      kbd_clk = 1'b1;
      repeat (HALF - 6 - glen) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    kbd_clk = 1'b0;
    model_sample(b);
    repeat (HALF) @(negedge clk);
    kbd_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] data, input bit par_ok, input bit stop,
                            input int gbit, input int glen);
    bit fb[11];
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[i+1] = data[i];
    fb[9]  = par_ok ? ~(^data) : (^data);
    fb[10] = stop;
    for (int i = 0; i < 11; i++) drive_bit(fb[i], (i == gbit) ? glen : 0);
    kbd_dat = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (dout !== 8'h00) begin
      errors++;
      $display("FAIL %s_dout got %02h required 00", tag, dout);
    end
    checks++;
    if (dout_new !== 1'b0) begin
      errors++;
      $display("FAIL %s_dout_new got %b required 0", tag, dout_new);
    end
    checks++;
    if (parity_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_parity_err got %b required 0", tag, parity_err);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_frame_err got %b required 0", tag, frame_err);
    end
  endtask

  always @(negedge clk) begin : monitor
    int   nstb;
    int   got_kind;
    int   delta;
    exp_t e;
    if (resetN) begin
      nstb = int'(dout_new) + int'(parity_err) + int'(frame_err);
      if (nstb != 0) begin
        checks++;
        if (nstb > 1) begin
          errors++;
          $display("FAIL strobe_excl got new=%b perr=%b ferr=%b required one", dout_new, parity_err, frame_err);
        end
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe got new=%b perr=%b ferr=%b required none", dout_new, parity_err, frame_err);
        end else begin
          e        = sb.pop_front();
          got_kind = dout_new ? 0 : (parity_err ? 1 : 2);
          checks++;
          if (got_kind != e.kind) begin
            errors++;
            $display("FAIL strobe_kind got %0d required %0d", got_kind, e.kind);
          end
          delta = int'(cyc - e.edge_cyc);
          checks++;
          if (delta < 5 || delta > 9) begin
            errors++;
            $display("FAIL strobe_latency got %0d required 5..9", delta);
          end
          if (e.kind == 0) model_dout = e.data;
          checks++;
          if (dout !== model_dout) begin
            errors++;
            $display("FAIL dout_at_strobe got %02h required %02h", dout, model_dout);
          end
        end
      end else begin
        checks++;
        if (dout !== model_dout) begin
          errors++;
          $display("FAIL dout_hold got %02h required %02h", dout, model_dout);
        end
      end
    end
  end

  initial begin
    logic [7:0] d;
    #2 resetN = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetN = 1'b1;
    repeat (10) @(negedge clk);

    // Directed frames
    send_frame(8'h1C, 1'b1, 1'b1, -1, 0);
    send_frame(8'hF0, 1'b1, 1'b1, -1, 0);
    send_frame(8'h1C, 1'b1, 1'b1, -1, 0);
    send_frame(8'h5A, 1'b0, 1'b1, -1, 0);
    send_frame(8'h5A, 1'b1, 1'b0, -1, 0);
    send_frame(8'h5A, 1'b0, 1'b0, -1, 0);

    // Partial frame abandoned until the timeout fires
    drive_bit(1'b0, 0);
    drive_bit(1'b0, 0);
    drive_bit(1'b1, 0);
    drive_bit(1'b0, 0);
    kbd_dat = 1'b1;
    repeat (TIMEOUT_CYC + 10) @(negedge clk);
    send_frame(8'h5A, 1'b1, 1'b1, -1, 0);

    // Short glitch is filtered; long glitch is seen as an extra edge
    send_frame(8'h1C, 1'b1, 1'b1, 3, 2);
    send_frame(8'hA5, 1'b1, 1'b1, 4, 4);
    send_frame(8'h3B, 1'b1, 1'b1, -1, 0);

    // Randomized frames, with occasional bad parity/stop and clock glitches
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      send_frame(d, ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 9)) : -1,
                 int'($urandom_range(1, 5)));
    end
    kbd_dat = 1'b1;
    repeat (TIMEOUT_CYC + 10) @(negedge clk);

    // Reset in the middle of a frame
    send_frame(8'hF0, 1'b1, 1'b1, -1, 0);
    drive_bit(1'b0, 0);
    for (int i = 0; i < 5; i++) drive_bit(((8'h1C >> i) & 8'h01) != 0, 0);
    @(posedge clk);
    #2;
    resetN  = 1'b0;
    kbd_clk = 1'b1;
    kbd_dat = 1'b1;
    rx_bits.delete();
    model_dout = 8'h00;
    #1;
    check_reset_outputs("midframe_reset");
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h1C, 1'b1, 1'b1, -1, 0);

    repeat (50) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_strobes got %0d outstanding required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
